// File: rtl/canny_nms_threshold.sv
// Canny non-maximum suppression and double-threshold classifier.
// The block builds a 3x3 window of {dir,mag} words from two line buffers,
// keeps the centre pixel only if it is a local maximum along its gradient
// direction, then grades it against per-frame low/high thresholds.
// The output is a 2-bit code (10 strong, 01 weak, 00 none) for the
// hysteresis stage.
//
// Ports:
//   clk, rst_s              pixel clock, asynchronous active-high reset
//   pre_frame_vsync/href/clken  input video timing
//   mag, dir                gradient magnitude and quantised direction
//                           (0=0deg 1=45deg 2=90deg 3=135deg)
//   high_th, low_th         thresholds, captured on each vsync rising edge
//   post_frame_vsync/href/clken input timing delayed by 3 clk
//   max_g                   code for window centre (r-1, c-1), aligned with post_frame_clken
module canny_nms_threshold #(
    parameter int unsigned MAG_WIDTH  = 11,
    parameter int unsigned DATA_DEPTH = 640
) (
    input  logic                 clk,
    input  logic                 rst_s,
    input  logic                 pre_frame_vsync,
    input  logic                 pre_frame_href,
    input  logic                 pre_frame_clken,
    input  logic [MAG_WIDTH-1:0] mag,
    input  logic [1:0]           dir,
    input  logic [MAG_WIDTH-1:0] high_th,
    input  logic [MAG_WIDTH-1:0] low_th,
    output logic                 post_frame_vsync,
    output logic                 post_frame_href,
    output logic                 post_frame_clken,
    output logic [1:0]           max_g
);

    localparam int unsigned WORD_W = MAG_WIDTH + 2;
    localparam int unsigned COL_W  = (DATA_DEPTH > 2) ? $clog2(DATA_DEPTH) : 1;

    logic [2:0]           r_vsync_d;
    logic [2:0]           r_href_d;
    logic [2:0]           r_clken_d;
    logic                 w_accept;
    logic                 w_vsync_rise;
    logic                 w_href_fall;

    logic [COL_W-1:0]     r_col;
    logic [1:0]           r_row;
    logic [MAG_WIDTH-1:0] r_high;
    logic [MAG_WIDTH-1:0] r_low;
    logic [MAG_WIDTH-1:0] w_low_eff;
    logic                 r_started;

    logic [WORD_W-1:0]    r_lb0 [DATA_DEPTH];
    logic [WORD_W-1:0]    r_lb1 [DATA_DEPTH];
    logic [WORD_W-1:0]    w_pix;

    // Window indexed [row][col]; row 0 is the oldest line, col 0 the oldest column.
    logic [WORD_W-1:0]    r_win [3][3];
    logic                 r_s1_vld;
    logic                 r_s1_ok;

    logic [MAG_WIDTH-1:0] w_mag_c;
    logic [MAG_WIDTH-1:0] w_mag_a;
    logic [MAG_WIDTH-1:0] w_mag_b;
    logic [1:0]           w_dir_c;
    logic                 w_keep;

    logic                 r_s2_vld;
    logic                 r_s2_keep;
    logic [MAG_WIDTH-1:0] r_s2_mag;
    logic [1:0]           r_max_g;

    assign w_accept     = pre_frame_href & pre_frame_clken;
    assign w_vsync_rise = pre_frame_vsync & ~r_vsync_d[0];
    assign w_href_fall  = ~pre_frame_href & r_href_d[0];
    assign w_pix        = {dir, mag};
    assign w_low_eff    = (r_low < r_high) ? r_low : r_high;

    assign post_frame_vsync = r_vsync_d[2];
    assign post_frame_href  = r_href_d[2];
    assign post_frame_clken = r_clken_d[2];
    assign max_g            = r_max_g;

    // Timing delay line; bit 0 doubles as the previous-cycle value for edge detect.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            r_vsync_d <= '0;
            r_href_d  <= '0;
            r_clken_d <= '0;
        end else begin
            r_vsync_d <= {r_vsync_d[1:0], pre_frame_vsync};
            r_href_d  <= {r_href_d[1:0], pre_frame_href};
            r_clken_d <= {r_clken_d[1:0], pre_frame_clken};
        end
    end

    // Position counters, per-frame thresholds and the started flag.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            r_col     <= '0;
            r_row     <= '0;
            r_high    <= '0;
            r_low     <= '0;
            r_started <= 1'b0;
        end else begin
            if (w_vsync_rise) begin
                r_row <= '0;
            end else if (w_href_fall && (r_row != 2'd2)) begin
                r_row <= r_row + 2'd1;
            end

            if (w_href_fall) begin
                r_col <= '0;
            end else if (w_accept) begin
                r_col <= (r_col == COL_W'(DATA_DEPTH - 1)) ? '0 : r_col + COL_W'(1);
            end

            if (w_vsync_rise) begin
                r_high    <= high_th;
                r_low     <= low_th;
                r_started <= 1'b1;
            end
        end
    end

    // Line buffers: lb0 holds the previous line, lb1 the one before it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb0[r_col] <= w_pix;
            r_lb1[r_col] <= r_lb0[r_col];
        end
    end

    // Stage 1: shift the window one column on each accepted pixel.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_win[i][j] <= '0;
                end
            end
            r_s1_vld <= 1'b0;
            r_s1_ok  <= 1'b0;
        end else begin
            if (w_accept) begin
                for (int i = 0; i < 3; i++) begin
                    r_win[i][0] <= r_win[i][1];
                    r_win[i][1] <= r_win[i][2];
                end
                r_win[0][2] <= r_lb1[r_col];
                r_win[1][2] <= r_lb0[r_col];
                r_win[2][2] <= w_pix;
            end
            r_s1_vld <= w_accept;
            // Centre is only meaningful once two full lines and two columns are in.
            r_s1_ok  <= (r_row == 2'd2) && (r_col >= COL_W'(2));
        end
    end

    // Neighbour pair along the gradient; a is the earlier one in raster order.
    always_comb begin
        w_mag_c = r_win[1][1][MAG_WIDTH-1:0];
        w_dir_c = r_win[1][1][WORD_W-1 -: 2];
        w_mag_a = '0;
        w_mag_b = '0;
        case (w_dir_c)
            2'd0: begin
                w_mag_a = r_win[1][0][MAG_WIDTH-1:0];
                w_mag_b = r_win[1][2][MAG_WIDTH-1:0];
            end
            2'd1: begin
                w_mag_a = r_win[0][2][MAG_WIDTH-1:0];
                w_mag_b = r_win[2][0][MAG_WIDTH-1:0];
            end
            2'd2: begin
                w_mag_a = r_win[0][1][MAG_WIDTH-1:0];
                w_mag_b = r_win[2][1][MAG_WIDTH-1:0];
            end
            default: begin
                w_mag_a = r_win[0][0][MAG_WIDTH-1:0];
                w_mag_b = r_win[2][2][MAG_WIDTH-1:0];
            end
        endcase
        // Strict against a only, so a plateau keeps its first pixel.
        w_keep = (w_mag_c > w_mag_a) && (w_mag_c >= w_mag_b);
    end

    // Stage 2 registers the NMS result; stage 3 grades against the thresholds.
    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            r_s2_vld  <= 1'b0;
            r_s2_keep <= 1'b0;
            r_s2_mag  <= '0;
            r_max_g   <= 2'b00;
        end else begin
            r_s2_vld  <= r_s1_vld & r_s1_ok;
            r_s2_keep <= w_keep;
            r_s2_mag  <= w_mag_c;
            if (r_s2_vld && r_s2_keep && r_started) begin
                if (r_s2_mag >= r_high) begin
                    r_max_g <= 2'b10;
                end else if (r_s2_mag >= w_low_eff) begin
                    r_max_g <= 2'b01;
                end else begin
                    r_max_g <= 2'b00;
                end
            end else begin
                r_max_g <= 2'b00;
            end
        end
    end

endmodule

// File: tb/tb_canny_nms_threshold.sv
// Bench for canny_nms_threshold on an 8x6 frame with DATA_DEPTH = 8.
// The driver builds each frame from a base magnitude plus ridges or spots.
// Every accepted pixel queues its hand-derived code. A monitor pops and
// compares whenever post_frame_clken is high, and checks that the timing
// outputs trail the inputs.
`timescale 1ns/1ps
module tb_canny_nms_threshold;

    localparam int unsigned MAG_W = 11;
    localparam int unsigned DEPTH = 8;
    localparam int ROWS = 6;
    localparam int COLS = 8;

    logic             clk = 1'b0;
    logic             rst_s;
    logic             pre_frame_vsync;
    logic             pre_frame_href;
    logic             pre_frame_clken;
    logic [MAG_W-1:0] mag;
    logic [1:0]       dir;
    logic [MAG_W-1:0] high_th;
    logic [MAG_W-1:0] low_th;
    logic             post_frame_vsync;
    logic             post_frame_href;
    logic             post_frame_clken;
    logic [1:0]       max_g;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_q [$];
    int         img [ROWS][COLS];
    logic [1:0] exp_map [ROWS][COLS];
    bit         tb_started = 1'b0;

    always #5 clk = ~clk;

    canny_nms_threshold #(
        .MAG_WIDTH (MAG_W),
        .DATA_DEPTH(DEPTH)
    ) dut (
        .clk             (clk),
        .rst_s           (rst_s),
        .pre_frame_vsync (pre_frame_vsync),
        .pre_frame_href  (pre_frame_href),
        .pre_frame_clken (pre_frame_clken),
        .mag             (mag),
        .dir             (dir),
        .high_th         (high_th),
        .low_th          (low_th),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .max_g           (max_g)
    );

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, req, $time);
        end
    endtask

    // Image and expected-centre builders.
    task automatic clr(input int base);
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                img[r][c]     = base;
                exp_map[r][c] = 2'b00;
            end
        end
    endtask

    task automatic set_col(input int c, input int m);
        for (int r = 0; r < ROWS; r++) img[r][c] = m;
    endtask

    task automatic set_row(input int r, input int m);
        for (int c = 0; c < COLS; c++) img[r][c] = m;
    endtask

    task automatic exp_col(input int c, input logic [1:0] code);
        for (int r = 1; r < ROWS - 1; r++) exp_map[r][c] = code;
    endtask

    task automatic exp_row(input int r, input logic [1:0] code);
        for (int c = 1; c < COLS - 1; c++) exp_map[r][c] = code;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_vsync"}, int'(post_frame_vsync), 0);
        check({tag, "_href"}, int'(post_frame_href), 0);
        check({tag, "_clken"}, int'(post_frame_clken), 0);
        check({tag, "_max_g"}, int'(max_g), 0);
    endtask

    // Two-cycle reset in the middle of a line; in-flight results are dropped.
    task automatic do_reset();
        @(negedge clk);
        rst_s           = 1'b1;
        pre_frame_clken = 1'b0;
        exp_q.delete();
        tb_started      = 1'b0;
        #1;
        check("rst_async_href", int'(post_frame_href), 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_outputs_zero("rst_mid");
        end
        @(negedge clk);
        rst_s = 1'b0;
    endtask

    task automatic run_frame(input int dir_v, input int hi, input int lo,
                             input int mid_hi, input int mid_lo, input int gap,
                             input int rst_r, input int rst_c);
        @(negedge clk);
        pre_frame_vsync = 1'b1;
        high_th         = MAG_W'(hi);
        low_th          = MAG_W'(lo);
        tb_started      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pre_frame_vsync = 1'b0;
        @(negedge clk);
        for (int r = 0; r < ROWS; r++) begin
            if (r == 1) begin
                high_th = MAG_W'(mid_hi);
                low_th  = MAG_W'(mid_lo);
            end
            for (int c = 0; c < COLS; c++) begin
                if (r == rst_r && c == rst_c) do_reset();
                if (gap > 0 && (c % gap) == gap - 1) begin
                    @(negedge clk);
                    pre_frame_href  = 1'b1;
                    pre_frame_clken = 1'b0;
                end
                @(negedge clk);
                pre_frame_href  = 1'b1;
                pre_frame_clken = 1'b1;
                mag             = MAG_W'(img[r][c]);
                dir             = 2'(dir_v);
                exp_q.push_back((tb_started && r >= 1 && c >= 1) ? exp_map[r-1][c-1] : 2'b00);
            end
            @(negedge clk);
            pre_frame_href  = 1'b0;
            pre_frame_clken = 1'b0;
            repeat (2) @(negedge clk);
        end
    endtask

    // Monitor: timing alignment every cycle, scoreboard pop on each output pixel.
    initial begin
        logic [2:0] ha;
        logic [2:0] hb;
        logic [2:0] cur;
        logic [2:0] post;
        logic [1:0] e;
        ha = '0;
        hb = '0;
        forever begin
            @(posedge clk);
            #1;
            cur = {pre_frame_vsync, pre_frame_href, pre_frame_clken};
            if (rst_s) begin
                ha = '0;
                hb = '0;
            end else begin
                post = {post_frame_vsync, post_frame_href, post_frame_clken};
                check("timing", int'(post), int'(hb));
                if (post_frame_clken) begin
                    if (exp_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("max_g", int'(max_g), int'(e));
                    end
                end else begin
                    check("idle_max_g", int'(max_g), 0);
                end
                hb = ha;
                ha = cur;
            end
        end
    end

    initial begin
        rst_s           = 1'b1;
        pre_frame_vsync = 1'b0;
        pre_frame_href  = 1'b0;
        pre_frame_clken = 1'b0;
        mag             = '0;
        dir             = '0;
        high_th         = '0;
        low_th          = '0;
        @(posedge clk);
        #1;
        check_outputs_zero("reset");
        repeat (2) @(negedge clk);
        rst_s = 1'b0;

        // All-zero frame: nothing survives NMS.
        clr(0);
        run_frame(0, 100, 50, 100, 50, 0, -1, -1);

        // Vertical ridge at column 4, strong / weak / below low.
        clr(10); set_col(4, 200); exp_col(4, 2'b10);
        run_frame(0, 100, 50, 100, 50, 0, -1, -1);
        clr(10); set_col(4, 70); exp_col(4, 2'b01);
        run_frame(0, 100, 50, 100, 50, 0, -1, -1);
        clr(10); set_col(4, 40);
        run_frame(0, 100, 50, 100, 50, 0, -1, -1);

        // Two-column plateau: only the first column survives.
        clr(10); set_col(3, 200); set_col(4, 200); exp_col(3, 2'b10);
        run_frame(0, 100, 50, 100, 50, 0, -1, -1);

        // low > high collapses to low = high; mid-frame threshold changes ignored.
        clr(10); set_col(4, 120); exp_col(4, 2'b10);
        run_frame(0, 100, 150, 300, 250, 0, -1, -1);

        // 90deg: horizontal plateau on rows 2 and 3.
        clr(10); set_row(2, 200); set_row(3, 200); exp_row(2, 2'b10);
        run_frame(2, 100, 50, 100, 50, 0, -1, -1);

        // 45deg: (3,4) is suppressed by its top-right neighbour (2,5).
        clr(10); img[3][4] = 200; img[2][5] = 250; exp_map[2][5] = 2'b10;
        run_frame(1, 100, 50, 100, 50, 0, -1, -1);

        // 135deg: (3,4) is suppressed by its top-left neighbour (2,3).
        clr(10); img[3][4] = 200; img[2][3] = 250; exp_map[2][3] = 2'b10;
        run_frame(3, 100, 50, 100, 50, 0, -1, -1);

        // Reset mid-frame, then a normal frame with idle gaps inside lines.
        clr(10); set_col(4, 200); exp_col(4, 2'b10);
        run_frame(0, 100, 50, 100, 50, 0, 3, 3);
        run_frame(0, 100, 50, 100, 50, 3, -1, -1);

        repeat (10) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
